// File: rtl/uart_pkg.sv
// uart_pkg: shared parity-mode constants and receiver state type
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BITS} rx_state_e;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads RESET_VAL into both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output
module uart_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      q_o    <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with configurable data width, parity and stop bits
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   baud_rate_i  : clk_i cycles per bit, latched at each start edge (min 4)
//   rx_i         : serial line, idle high, asynchronous to clk_i
//   data_o       : last received word (LSB first on the line)
//   valid_o      : one-cycle pulse when data_o updates
//   parity_err_o : parity mismatch for the word on data_o
//   frame_err_o  : a stop bit was sampled low for the word on data_o
//   busy_o       : receiver is inside a frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH     = 32,
  parameter int NUM_STOP_BITS = 1,
  parameter int PARITY_MODE   = PARITY_NONE,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [MAX_WIDTH-1:0]  baud_rate_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(NUM_STOP_BITS - 1);
  logic                  rx_s;
  logic                  sample;
  rx_state_e             state_q;
  logic [MAX_WIDTH-1:0]  baud_q, cnt_q;
  logic [3:0]            bit_q;
  logic [DATA_WIDTH-1:0] shift_q, data_q;
  logic                  par_q, frm_q, par_err_q, frm_err_q, valid_q, busy_q;
  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );
  // Start bit is sampled half a bit in; every later bit one full bit after the previous sample.
  assign sample = cnt_q == ((state_q == START_BIT) ? (baud_q >> 1) : baud_q) - 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      frm_q     <= 1'b0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      cnt_q   <= sample ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          par_q <= 1'b0;
          frm_q <= 1'b0;
          if (!rx_s) begin
            state_q <= START_BIT;
            baud_q  <= baud_rate_i;
            busy_q  <= 1'b1;
          end
        end
        START_BIT: if (sample) begin
          // A line back high at mid start bit is a glitch, not a frame.
          state_q <= rx_s ? IDLE : DATA_BITS;
          busy_q  <= !rx_s;
        end
        DATA_BITS: if (sample) begin
          shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_q   <= '0;
            state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY_BIT : STOP_BITS;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        PARITY_BIT: if (sample) begin
          // Mismatch when the received bit differs from the expected even/odd parity bit.
          par_q   <= rx_s ^ (^shift_q) ^ (PARITY_MODE == PARITY_ODD);
          state_q <= STOP_BITS;
        end
        STOP_BITS: if (sample) begin
          if (bit_q == LAST_STOP) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= shift_q;
            par_err_q <= par_q;
            frm_err_q <= frm_q | !rx_s;
          end else begin
            bit_q <= bit_q + 1'b1;
            frm_q <= frm_q | !rx_s;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = par_err_q;
  assign frame_err_o  = frm_err_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against an 8N1 and an 8E1 receiver
module tb_uart_rx;
  logic        clk_i = 1'b0, rst_ni = 1'b0, rx = 1'b1, sel = 1'b0;
  logic [31:0] baud = 32'd16;
  logic        rx_n, rx_e;
  logic [7:0]  data_n, data_e;
  logic        valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e, busy_n, busy_e;
  int          cyc = 0, checks = 0, errors = 0;
  int          n_valid_n = 0, n_valid_e = 0, last_cyc_n = 0, t_start = 0;
  logic [9:0]  q_n[$], q_e[$];
  assign rx_n = sel ? 1'b1 : rx;
  assign rx_e = sel ? rx : 1'b1;
  uart_rx #(.MAX_WIDTH(32), .NUM_STOP_BITS(1), .PARITY_MODE(0), .DATA_WIDTH(8)) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .baud_rate_i(baud), .rx_i(rx_n), .data_o(data_n),
    .valid_o(valid_n), .parity_err_o(perr_n), .frame_err_o(ferr_n), .busy_o(busy_n));
  uart_rx #(.MAX_WIDTH(32), .NUM_STOP_BITS(1), .PARITY_MODE(1), .DATA_WIDTH(8)) dut_e (
    .clk_i(clk_i), .rst_ni(rst_ni), .baud_rate_i(baud), .rx_i(rx_e), .data_o(data_e),
    .valid_o(valid_e), .parity_err_o(perr_e), .frame_err_o(ferr_e), .busy_o(busy_e));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // Expected words are {data, parity_err, frame_err}, popped in order as valid pulses arrive.
  always @(negedge clk_i) begin
    logic [9:0] e;
    if (valid_n) begin
      n_valid_n++;
      last_cyc_n = cyc;
      if (q_n.size() == 0) check("n_unexpected_valid", valid_n, 0);
      else begin
        e = q_n.pop_front();
        check("n_data", data_n, e[9:2]);
        check("n_perr", perr_n, e[1]);
        check("n_ferr", ferr_n, e[0]);
      end
    end
    if (valid_e) begin
      n_valid_e++;
      if (q_e.size() == 0) check("e_unexpected_valid", valid_e, 0);
      else begin
        e = q_e.pop_front();
        check("e_data", data_e, e[9:2]);
        check("e_perr", perr_e, e[1]);
        check("e_ferr", ferr_e, e[0]);
      end
    end
  end
  task automatic bit_out(input logic b);
    rx = b;
    repeat (baud) @(posedge clk_i);
    #1;
  endtask
  task automatic send(input logic s, input int b, input logic [7:0] d, input logic pbit,
                      input logic stop, input int gap);
    sel  = s;
    baud = b;
    if (s) q_e.push_back({d, pbit != ^d, !stop});
    else   q_n.push_back({d, 1'b0, !stop});
    t_start = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (s) bit_out(pbit);
    bit_out(stop);
    repeat (gap) bit_out(1'b1);
  endtask
  initial begin
    int nv, found;
    logic [7:0] d;
    logic stop;
    repeat (3) @(negedge clk_i);
    check("rst_data_n", data_n, 0);
    check("rst_valid_n", valid_n, 0);
    check("rst_perr_n", perr_n, 0);
    check("rst_ferr_n", ferr_n, 0);
    check("rst_busy_n", busy_n, 0);
    check("rst_data_e", data_e, 0);
    check("rst_busy_e", busy_e, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    // 8N1 0xA5: pulse one cycle after the mid-stop sample (2 sync flops + detect + half bit + 9 bits)
    nv = n_valid_n;
    send(1'b0, 16, 8'hA5, 1'b0, 1'b1, 1);
    check("a5_pulses", n_valid_n, nv + 1);
    check("a5_latency", last_cyc_n - t_start, 3 + 8 + 9 * 16);
    // 3-cycle glitch on the line
    nv = n_valid_n;
    sel = 1'b0; baud = 16; rx = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    rx = 1'b1;
    check("glitch_busy_rise", busy_n, 1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk_i);
      if (!busy_n) found = 1;
    end
    check("glitch_busy_fall", found, 1);
    repeat (40) @(posedge clk_i); #1;
    check("glitch_no_valid", n_valid_n, nv);
    check("glitch_data_hold", data_n, 8'hA5);
    // even parity, 0x3C with wrong then correct parity bit
    send(1'b1, 16, 8'h3C, 1'b1, 1'b1, 0);
    send(1'b1, 16, 8'h3C, 1'b0, 1'b1, 1);
    check("par_hold", perr_e, 0);
    // 0x55 with a low stop bit still presents the word
    nv = n_valid_n;
    send(1'b0, 16, 8'h55, 1'b0, 1'b0, 2);
    check("ferr_pulses", n_valid_n, nv + 1);
    check("ferr_hold", ferr_n, 1);
    // back-to-back frames at baud 10
    nv = n_valid_n;
    send(1'b0, 10, 8'h01, 1'b0, 1'b1, 0);
    send(1'b0, 10, 8'hFF, 1'b0, 1'b1, 0);
    send(1'b0, 10, 8'h80, 1'b0, 1'b1, 1);
    check("b2b_pulses", n_valid_n, nv + 3);
    // reset during bit 4 of 0xA5
    nv = n_valid_n;
    sel = 1'b0; baud = 16; d = 8'hA5;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    rx = d[4];
    repeat (8) @(posedge clk_i); #1;
    rst_ni = 1'b0;
    rx = 1'b1;
    @(negedge clk_i);
    check("midrst_data", data_n, 0);
    check("midrst_valid", valid_n, 0);
    check("midrst_perr", perr_n, 0);
    check("midrst_ferr", ferr_n, 0);
    check("midrst_busy", busy_n, 0);
    repeat (3) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (60) @(posedge clk_i); #1;
    check("midrst_no_valid", n_valid_n, nv);
    check("midrst_idle", busy_n, 0);
    send(1'b0, 16, 8'h12, 1'b0, 1'b1, 1);
    check("after_rst_data", data_n, 8'h12);
    // random traffic on both receivers
    for (int f = 0; f < 40; f++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      send(1'($urandom_range(0, 1)), $urandom_range(4, 20), d,
           (^d) ^ ($urandom_range(0, 3) == 0), stop,
           stop ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    repeat (100) @(posedge clk_i); #1;
    check("n_pending", q_n.size(), 0);
    check("e_pending", q_e.size(), 0);
    check("end_idle_n", busy_n, 0);
    check("end_idle_e", busy_e, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
